alu_serial_seq: RTL and testbench

Bit-serial sequencer for the 24-bit ALU. It accepts one operation with two WIDTH-bit operands and drives a single 1-bit ALU slice once per clock, LSB first, carrying the slice's carry-out into the next bit. It returns the full result and flags after WIDTH (+1 for SLT) cycles. It sits between the CPU control unit and the ALU slice, replacing a WIDTH-slice ripple array where area matters more than latency.

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/ALU_1BIT.sv | 20 ++
 rtl/alu_serial_seq.sv | 113 +++++++++++
 tb/tb_alu_serial_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, FSM states, slice control and op decode for alu_serial_seq (SLT gated by ALU_SEQ_SLT_EN)
package alu_seq_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b111;
`ifdef ALU_SEQ_SLT_EN
  typedef enum logic [1:0] {IDLE, SHIFT, SLT_FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic       cin0;
    logic [1:0] operation;
  } slice_ctl_t;
  function automatic slice_ctl_t decode(input logic [2:0] op);
    case (op)
      OP_OR:          return slice_ctl_t'(5'b00001);
      OP_ADD:         return slice_ctl_t'(5'b00010);
      OP_SUB, OP_SLT: return slice_ctl_t'(5'b01110);
      OP_NOR:         return slice_ctl_t'(5'b11000);
      default:        return slice_ctl_t'(5'b00000);
    endcase
  endfunction
  function automatic logic is_legal(input logic [2:0] op);
`ifdef ALU_SEQ_SLT_EN
    return op != 3'b011 && op != 3'b101;
`else
    return op != 3'b011 && op != 3'b101 && op != OP_SLT;
`endif
  endfunction
endpackage

// File: rtl/ALU_1BIT.sv
// ALU_1BIT: one-bit ALU slice with operand inversion, AND/OR/add/less select
module ALU_1BIT (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_ainv,
  input  logic       i_binv,
  input  logic       i_cin,
  input  logic       i_less,
  input  logic [1:0] i_operation,
  output logic       o_result,
  output logic       o_cout
);
  logic w_a, w_b;
  assign w_a = i_a ^ i_ainv;
  assign w_b = i_b ^ i_binv;
  assign o_cout = (w_a & w_b) | (i_cin & (w_a ^ w_b));
  assign o_result = i_operation == 2'b00 ? w_a & w_b :
                    i_operation == 2'b01 ? w_a | w_b :
                    i_operation == 2'b10 ? w_a ^ w_b ^ i_cin : i_less;
endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU sequencer driving one ALU_1BIT slice LSB first (SLT when ALU_SEQ_SLT_EN defined)
module alu_serial_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_result, w_final;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_zero, r_ovf, r_cout, r_illegal;
  logic             w_accept, w_last, w_cin, w_res, w_cout, w_arith;
  slice_ctl_t       w_ctl;
  assign w_ctl    = decode(r_op);
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = r_cnt == CW'(WIDTH - 1);
  assign w_cin    = r_cnt == '0 ? w_ctl.cin0 : r_carry;
  assign w_arith  = w_ctl.operation == 2'b10;
  // bits above the current one are still zero, so this is the completed result on the last bit
  assign w_final  = {w_res, r_result[WIDTH-2:0]};
  ALU_1BIT u_slice (
    .i_a        (r_a[r_cnt]),
    .i_b        (r_b[r_cnt]),
    .i_ainv     (w_ctl.ainv),
    .i_binv     (w_ctl.binv),
    .i_cin      (w_cin),
    .i_less     (1'b0),
    .i_operation(w_ctl.operation),
    .o_result   (w_res),
    .o_cout     (w_cout)
  );
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = w_accept ? (is_legal(op) ? SHIFT : DONE) : IDLE;
`ifdef ALU_SEQ_SLT_EN
      SHIFT:      w_next = w_last ? (r_op == OP_SLT ? SLT_FIX : DONE) : SHIFT;
      SLT_FIX:    w_next = DONE;
`else
      SHIFT:      w_next = w_last ? DONE : SHIFT;
`endif
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_cout    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_a       <= a;
      r_b       <= b;
      r_op      <= op;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_cout    <= 1'b0;
      r_illegal <= !is_legal(op);
    end else if (r_state == SHIFT) begin
      r_result[r_cnt] <= w_res;
      r_carry         <= w_cout;
      r_cnt           <= r_cnt + 1'b1;
      if (w_last) begin
        r_ovf  <= w_arith & (r_carry ^ w_cout);
        r_cout <= w_arith & w_cout;
        r_zero <= ~|w_final;
      end
`ifdef ALU_SEQ_SLT_EN
    end else if (r_state == SLT_FIX) begin
      r_result <= {{(WIDTH-1){1'b0}}, r_result[WIDTH-1] ^ r_ovf};
      r_zero   <= ~(r_result[WIDTH-1] ^ r_ovf);
      r_ovf    <= 1'b0;
      r_cout   <= 1'b0;
`endif
    end
  end
`ifdef ALU_SEQ_SLT_EN
  assign busy = r_state == SHIFT || r_state == SLT_FIX;
`else
  assign busy = r_state == SHIFT;
`endif
  assign done      = r_state == DONE;
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_ovf;
  assign carry_out = r_cout;
  assign illegal   = r_illegal;
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: table-driven directed checks of alu_serial_seq plus reset, ignored-start and back-to-back sequences
module tb_alu_serial_seq;
  import alu_seq_pkg::*;
  typedef struct {
    logic [2:0]  op;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] res;
    logic        z;
    logic        v;
    logic        c;
    logic        ill;
    int          cyc;
  } vec_t;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0]  op = '0;
  logic [23:0] a = '0, b = '0;
  logic        busy, done, zero, overflow, carry_out, illegal;
  logic [23:0] result;
  int          tests = 0, failed = 0, cyc;
  vec_t        vecs[$];
  alu_serial_seq #(.WIDTH(24)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .overflow(overflow), .carry_out(carry_out), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [23:0] x, input logic [23:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b011; a = 24'hA5A5A5; b = 24'h5A5A5A;
  endtask
  // returns the cycle number (E0 = accept edge) in which done is seen, 0 on timeout
  task automatic wait_done(output int c);
    c = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        c = k + 1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    vecs.push_back('{OP_ADD, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 1'b1, 1'b0, 1'b0, 25});
    vecs.push_back('{OP_SUB, 24'h000005, 24'h000007, 24'hFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 25});
    vecs.push_back('{OP_SUB, 24'h000007, 24'h000007, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 25});
    vecs.push_back('{OP_NOR, 24'h000000, 24'h000000, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 25});
    vecs.push_back('{OP_AND, 24'hF0F0F0, 24'hFF00FF, 24'hF000F0, 1'b0, 1'b0, 1'b0, 1'b0, 25});
    vecs.push_back('{OP_OR,  24'hF0F0F0, 24'h0F0000, 24'hFFF0F0, 1'b0, 1'b0, 1'b0, 1'b0, 25});
    vecs.push_back('{OP_ADD, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 25});
    vecs.push_back('{3'b011, 24'h123456, 24'h654321, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{3'b101, 24'h123456, 24'h654321, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 1});
`ifdef ALU_SEQ_SLT_EN
    vecs.push_back('{OP_SLT, 24'hFFFFFF, 24'h000001, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 26});
    vecs.push_back('{OP_SLT, 24'h7FFFFF, 24'h800000, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 26});
`else
    vecs.push_back('{OP_SLT, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 1});
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_flags", {zero, overflow, carry_out, illegal}, 0);
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(cyc);
      check($sformatf("v%0d_cycle", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_zero", i), zero, vecs[i].z);
      check($sformatf("v%0d_overflow", i), overflow, vecs[i].v);
      check($sformatf("v%0d_carry_out", i), carry_out, vecs[i].c);
      check($sformatf("v%0d_illegal", i), illegal, vecs[i].ill);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_held", i), result, vecs[i].res);
    end
    issue(OP_ADD, 24'hFFFFFF, 24'h000000);
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    check("mid_partial", result, 24'h0001FF);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_flags", {zero, overflow, carry_out, illegal}, 0);
    @(posedge clk); #1;
    check("abort_idle", {busy, done}, 0);
    issue(OP_ADD, 24'd3, 24'd4);
    wait_done(cyc);
    check("fresh_cycle", cyc, 25);
    check("fresh_result", result, 24'd7);
    @(posedge clk); #1;
    issue(OP_ADD, 24'd1, 24'd2);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = OP_SUB; a = 24'hFFFF00; b = 24'h0000FF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    check("ignored_cycle", cyc == 0 ? 0 : cyc + 5, 25);
    check("ignored_result", result, 24'd3);
    issue(OP_SUB, 24'd10, 24'd3);
    check("b2b_busy", busy, 1);
    check("b2b_done_low", done, 0);
    wait_done(cyc);
    check("b2b_cycle", cyc, 25);
    check("b2b_result", result, 24'd7);
    check("b2b_carry", carry_out, 1);
    @(posedge clk); #1;
    check("b2b_idle", {busy, done}, 0);
    check("b2b_held", result, 24'd7);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
